// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared constants and types for the rv32i memory arbiter.
package rv32i_mem_pkg;

   localparam int MEM_WORD_BITS  = 32;
   localparam int MEM_BE_BITS    = 4;
   localparam int MAX_PORTS      = 8;
   localparam int MAX_RD_LATENCY = 4;
   localparam int TAG_ID_BITS    = $clog2(MAX_PORTS);

   typedef struct packed {
      logic                   valid;
      logic [TAG_ID_BITS-1:0] id;
      logic                   err;
   } rsp_tag_t;

   // Port id width; a single port still needs one bit.
   function automatic int id_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: per-port request handshake plus shared response.
interface rv32i_mem_arbiter_if
   import rv32i_mem_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_BITS = 16
);
   logic [NUM_PORTS-1:0]                    req_valid;
   logic [NUM_PORTS-1:0]                    req_ready;
   logic [NUM_PORTS-1:0]                    req_we;
   logic [NUM_PORTS-1:0][ADDR_BITS-1:0]     req_addr;
   logic [NUM_PORTS-1:0][MEM_WORD_BITS-1:0] req_wdata;
   logic [NUM_PORTS-1:0][MEM_BE_BITS-1:0]   req_be;
   logic [NUM_PORTS-1:0]                    rsp_valid;
   logic [MEM_WORD_BITS-1:0]                rsp_rdata;
   logic                                    rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/rv32i_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner; outputs one-hot grant and its index.
module rr_arbiter
   import rv32i_mem_pkg::*;
#(
   parameter  int N   = 2,
   localparam int IDW = id_bits(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id
);

   logic           found;
   logic [IDW-1:0] cand;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      cand     = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IDW'((int'(last) + k) % N);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_id    = cand;
         end
      end
   end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Round-robin front-end sharing one single-port RAM among NUM_PORTS requesters.
// Optional RV32I_MEM_ARB_ALIGN_CHK_EN: misaligned requests skip the RAM and answer with rsp_err.
module rv32i_mem_arbiter
   import rv32i_mem_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_BITS  = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   rv32i_mem_arbiter_if.slave       bus,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [ADDR_BITS-3:0]     ram_addr,
   output logic [MEM_WORD_BITS-1:0] ram_wdata,
   output logic [MEM_BE_BITS-1:0]   ram_be,
   input  logic [MEM_WORD_BITS-1:0] ram_rdata
);

   localparam int IDW = id_bits(NUM_PORTS);

   if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
      $error("rv32i_mem_arbiter: NUM_PORTS out of range 1..8");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
      $error("rv32i_mem_arbiter: RD_LATENCY out of range 1..4");
   end
   if (ADDR_BITS < 3) begin : g_bad_addr
      $error("rv32i_mem_arbiter: ADDR_BITS too small");
   end

   logic [NUM_PORTS-1:0]             grant;
   logic [IDW-1:0]                   grant_id;
   logic [IDW-1:0]                   last_reg;
   logic                             accept;
   logic                             misalign;
   logic                             err_w;
   rsp_tag_t                         head;
   rsp_tag_t                         tail;
   rsp_tag_t [RD_LATENCY-1:0]        pipe_reg;

   rr_arbiter #(.N(NUM_PORTS)) u_rr (
      .req      (bus.req_valid),
      .last     (last_reg),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // Gating with reset_n keeps every strobe at its reset value while reset is held.
   assign accept        = reset_n && (|grant);
   assign bus.req_ready = accept ? grant : '0;

`ifdef RV32I_MEM_ARB_ALIGN_CHK_EN
   assign misalign = accept && (bus.req_addr[grant_id][1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign ram_en    = accept && !misalign;
   assign ram_we    = ram_en && bus.req_we[grant_id];
   assign ram_addr  = bus.req_addr[grant_id][ADDR_BITS-1:2];
   assign ram_wdata = bus.req_wdata[grant_id];
   assign ram_be    = ram_we ? bus.req_be[grant_id] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_reg <= IDW'(NUM_PORTS - 1);
      end else if (accept) begin
         last_reg <= grant_id;
      end
   end

   always_comb begin
      head       = '0;
      head.valid = accept;
      head.id    = TAG_ID_BITS'(grant_id);
      head.err   = misalign;
   end

   // The tag travels alongside the RAM read so its tail lines up with ram_rdata.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_reg <= '0;
      end else begin
         pipe_reg[0] <= head;
         for (int k = 1; k < RD_LATENCY; k++) begin
            pipe_reg[k] <= pipe_reg[k-1];
         end
      end
   end

   assign tail = pipe_reg[RD_LATENCY-1];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
      assign bus.rsp_valid[gi] = tail.valid && (tail.id == TAG_ID_BITS'(gi));
   end

   assign err_w         = tail.valid && tail.err;
   assign bus.rsp_err   = err_w;
   assign bus.rsp_rdata = err_w ? '0 : ram_rdata;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: three instances (RD_LATENCY 1..3) share directed stimulus; each has its own RAM and reference model.
`timescale 1ns/1ps
module tb_rv32i_mem_arbiter;
   import rv32i_mem_pkg::*;

   localparam int NP = 2;
   localparam int AB = 16;
`ifdef RV32I_MEM_ARB_ALIGN_CHK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [NP-1:0]          valid;
   logic [NP-1:0]          we;
   logic [NP-1:0][AB-1:0]  addr;
   logic [NP-1:0][31:0]    wdata;
   logic [NP-1:0][3:0]     be;

   typedef struct {
      int          due;
      int          port;
      bit          err;
      bit          rd;
      logic [31:0] data;
   } exp_rsp_t;

   function automatic logic [31:0] pat(input int a);
      return 32'h1000_0000 | 32'(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_lat
      localparam int LAT = gi + 1;

      rv32i_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_BITS(AB)) bus ();
      logic          ram_en;
      logic          ram_we;
      logic [AB-3:0] ram_addr;
      logic [31:0]   ram_wdata;
      logic [31:0]   ram_rdata;
      logic [3:0]    ram_be;
      logic [31:0]   ram_mem [int];
      logic [31:0]   rd_pipe [LAT];
      logic [31:0]   m_mem [int];
      exp_rsp_t      q [$];
      int            m_last;
      int            cyc = 0;

      assign bus.req_valid = valid;
      assign bus.req_we    = we;
      assign bus.req_addr  = addr;
      assign bus.req_wdata = wdata;
      assign bus.req_be    = be;

      rv32i_mem_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .RD_LATENCY(LAT)) dut (
         .clk       (clk),
         .reset_n   (rst_n),
         .bus       (bus),
         .ram_en    (ram_en),
         .ram_we    (ram_we),
         .ram_addr  (ram_addr),
         .ram_wdata (ram_wdata),
         .ram_be    (ram_be),
         .ram_rdata (ram_rdata)
      );

      // RAM behind the DUT: unwritten words read back as pat(word address).
      assign ram_rdata = rd_pipe[LAT-1];
      always @(posedge clk) begin
         logic [31:0] cur;
         cur = ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : pat(int'(ram_addr));
         if (ram_en && ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) cur[8*b +: 8] = ram_wdata[8*b +: 8];
            ram_mem[int'(ram_addr)] = cur;
         end
         rd_pipe[0] <= (ram_en && !ram_we) ? cur : 32'h0BAD_0BAD;
         for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
      end

      function automatic logic [31:0] m_rd(input int a);
         return m_mem.exists(a) ? m_mem[a] : pat(a);
      endfunction

      // Reference model: evaluated mid-cycle, then advanced as if past the coming edge.
      always @(negedge clk) begin
         int          win;
         bit          mis;
         int          wa;
         exp_rsp_t    e;
         logic [31:0] cur;
         if (!rst_n) begin
            chk($sformatf("L%0d rst req_ready", LAT), 32'(bus.req_ready), 32'h0);
            chk($sformatf("L%0d rst rsp_valid", LAT), 32'(bus.rsp_valid), 32'h0);
            chk($sformatf("L%0d rst rsp_err", LAT), 32'(bus.rsp_err), 32'h0);
            chk($sformatf("L%0d rst ram_en", LAT), 32'(ram_en), 32'h0);
            chk($sformatf("L%0d rst ram_we", LAT), 32'(ram_we), 32'h0);
            chk($sformatf("L%0d rst ram_be", LAT), 32'(ram_be), 32'h0);
            q.delete();
            m_last = NP - 1;
         end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
               chk($sformatf("L%0d rsp_valid", LAT), 32'(bus.rsp_valid), 32'(1 << q[0].port));
               chk($sformatf("L%0d rsp_err", LAT), 32'(bus.rsp_err), 32'(q[0].err));
               if (q[0].err)
                  chk($sformatf("L%0d rsp_rdata err", LAT), bus.rsp_rdata, 32'h0);
               else if (q[0].rd)
                  chk($sformatf("L%0d rsp_rdata", LAT), bus.rsp_rdata, q[0].data);
               void'(q.pop_front());
            end else begin
               chk($sformatf("L%0d rsp_valid idle", LAT), 32'(bus.rsp_valid), 32'h0);
            end

            win = -1;
            for (int k = 1; k <= NP; k++)
               if (win < 0 && valid[(m_last + k) % NP]) win = (m_last + k) % NP;

            if (win >= 0) begin
               chk($sformatf("L%0d req_ready", LAT), 32'(bus.req_ready), 32'(1 << win));
               mis = ALIGN_CHK && (addr[win][1:0] != 2'b00);
               wa  = int'(addr[win][AB-1:2]);
               chk($sformatf("L%0d ram_en", LAT), 32'(ram_en), 32'(!mis));
               chk($sformatf("L%0d ram_we", LAT), 32'(ram_we), 32'(!mis && we[win]));
               if (!mis) begin
                  chk($sformatf("L%0d ram_addr", LAT), 32'(ram_addr), 32'(wa));
                  if (we[win]) begin
                     chk($sformatf("L%0d ram_wdata", LAT), ram_wdata, wdata[win]);
                     chk($sformatf("L%0d ram_be", LAT), 32'(ram_be), 32'(be[win]));
                  end else begin
                     chk($sformatf("L%0d ram_be rd", LAT), 32'(ram_be), 32'h0);
                  end
               end
               e.due  = cyc + LAT;
               e.port = win;
               e.err  = mis;
               e.rd   = !we[win];
               e.data = m_rd(wa);
               q.push_back(e);
               if (we[win] && !mis) begin
                  cur = m_rd(wa);
                  for (int b = 0; b < 4; b++)
                     if (be[win][b]) cur[8*b +: 8] = wdata[win][8*b +: 8];
                  m_mem[wa] = cur;
               end
               m_last = win;
            end else begin
               chk($sformatf("L%0d req_ready idle", LAT), 32'(bus.req_ready), 32'h0);
               chk($sformatf("L%0d ram_en idle", LAT), 32'(ram_en), 32'h0);
            end
         end
         cyc++;
      end
   end

   task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [31:0] d1, input logic [3:0] b1);
      @(posedge clk);
      #1;
      valid    = v;
      we       = w;
      addr[0]  = a0;
      addr[1]  = a1;
      wdata[0] = 32'hA5A5_0000 | 32'(a0);
      wdata[1] = d1;
      be[0]    = 4'hF;
      be[1]    = b1;
      @(negedge clk);
   endtask

   task automatic idle();
      step(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 4'h0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      valid = '0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int cnt0;
      int cnt1;
      valid = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      be    = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle();

      // Single read, latency 1
      step(2'b01, 2'b00, 16'h0010, 16'h0, 32'h0, 4'h0);
      chk("L1 read ram_en", 32'(g_lat[0].ram_en), 32'h1);
      chk("L1 read ram_addr", 32'(g_lat[0].ram_addr), 32'h004);
      idle();
      chk("L1 read rsp_valid", 32'(g_lat[0].bus.rsp_valid), 32'h1);
      chk("L1 read rsp_rdata", g_lat[0].bus.rsp_rdata, 32'h1000_0004);

      // Pipelined reads, latency 3
      step(2'b01, 2'b00, 16'h0000, 16'h0, 32'h0, 4'h0);
      step(2'b01, 2'b00, 16'h0004, 16'h0, 32'h0, 4'h0);
      step(2'b01, 2'b00, 16'h0008, 16'h0, 32'h0, 4'h0);
      for (int k = 0; k < 3; k++) begin
         idle();
         chk($sformatf("L3 pipe rsp_valid %0d", k), 32'(g_lat[2].bus.rsp_valid), 32'h1);
         chk($sformatf("L3 pipe rsp_rdata %0d", k), g_lat[2].bus.rsp_rdata, 32'h1000_0000 + 32'(k));
      end

      // Byte write from port 1, then read back
      step(2'b10, 2'b10, 16'h0, 16'h0020, 32'hDEAD_BEEF, 4'b0010);
      chk("L1 wr ram_we", 32'(g_lat[0].ram_we), 32'h1);
      chk("L1 wr ram_be", 32'(g_lat[0].ram_be), 32'h2);
      chk("L1 wr ram_addr", 32'(g_lat[0].ram_addr), 32'h008);
      chk("L1 wr ram_wdata", g_lat[0].ram_wdata, 32'hDEAD_BEEF);
      idle();
      chk("L1 wr ack", 32'(g_lat[0].bus.rsp_valid), 32'h2);
      idle();
      chk("L2 wr ack", 32'(g_lat[1].bus.rsp_valid), 32'h2);
      step(2'b01, 2'b00, 16'h0020, 16'h0, 32'h0, 4'h0);
      idle();
      chk("L1 readback", g_lat[0].bus.rsp_rdata, 32'h1000_BE08);

      // Misaligned read
      step(2'b01, 2'b00, 16'h0013, 16'h0, 32'h0, 4'h0);
`ifdef RV32I_MEM_ARB_ALIGN_CHK_EN
      chk("L1 mis ram_en", 32'(g_lat[0].ram_en), 32'h0);
      idle();
      chk("L1 mis rsp_valid", 32'(g_lat[0].bus.rsp_valid), 32'h1);
      chk("L1 mis rsp_err", 32'(g_lat[0].bus.rsp_err), 32'h1);
      chk("L1 mis rsp_rdata", g_lat[0].bus.rsp_rdata, 32'h0);
`else
      chk("L1 mis ram_en", 32'(g_lat[0].ram_en), 32'h1);
      chk("L1 mis ram_addr", 32'(g_lat[0].ram_addr), 32'h004);
      idle();
      chk("L1 mis rsp_err", 32'(g_lat[0].bus.rsp_err), 32'h0);
      chk("L1 mis rsp_rdata", g_lat[0].bus.rsp_rdata, 32'h1000_0004);
`endif
      repeat (3) idle();

      // Contention after reset: port 0 first, strict alternation
      pulse_reset();
      cnt0 = 0;
      cnt1 = 0;
      for (int k = 0; k < 6; k++) begin
         step(2'b11, 2'b00, 16'h0040, 16'h0080, 32'h0, 4'h0);
         chk($sformatf("L1 contend grant %0d", k), 32'(g_lat[0].bus.req_ready),
             (k % 2 == 0) ? 32'h1 : 32'h2);
         cnt0 += int'(g_lat[0].bus.rsp_valid[0]);
         cnt1 += int'(g_lat[0].bus.rsp_valid[1]);
      end
      for (int k = 0; k < 3; k++) begin
         idle();
         cnt0 += int'(g_lat[0].bus.rsp_valid[0]);
         cnt1 += int'(g_lat[0].bus.rsp_valid[1]);
      end
      chk("L1 contend rsp count p0", 32'(cnt0), 32'd3);
      chk("L1 contend rsp count p1", 32'(cnt1), 32'd3);

      // Reset one cycle after an accepted read drops its response
      step(2'b10, 2'b00, 16'h0, 16'h0004, 32'h0, 4'h0);
      pulse_reset();
      chk("L2 flush rsp_valid 0", 32'(g_lat[1].bus.rsp_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         idle();
         chk($sformatf("L2 flush rsp_valid %0d", k + 1), 32'(g_lat[1].bus.rsp_valid), 32'h0);
      end
      step(2'b11, 2'b00, 16'h0100, 16'h0200, 32'h0, 4'h0);
      chk("L2 post-reset grant", 32'(g_lat[1].bus.req_ready), 32'h1);
      repeat (4) idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
